// File: rtl/stopwatch_disp_err.sv
// Display-output stage for the stopwatch: forwards BCD digits to the decoders and
// replaces them with a flashing error pattern when the direction flips while running.
module stopwatch_disp_err #(
    parameter int           NDIG       = 4,
    parameter int           BLINK_DIV  = 25_000_000,
    parameter int           BLINKS     = 0,
    parameter logic [3:0]   ERR_EVEN   = 4'h3,
    parameter logic [3:0]   ERR_ODD    = 4'hF,
    parameter logic [3:0]   BLANK_CODE = 4'hA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up,
    input  logic              start,
    input  logic              blank_sel,
    input  logic              err_clr,
    input  logic [4*NDIG-1:0] digits_in,
    output logic [4*NDIG-1:0] digits_out,
    output logic              err_active
);
    localparam int PH_W = $clog2(BLINK_DIV);
    localparam int BL_W = ($clog2(BLINKS + 1) < 1) ? 1 : $clog2(BLINKS + 1);

    typedef enum logic [1:0] {NORM, ERR_SHOW, ERR_BLANK} state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [BL_W-1:0]   r_bl_cnt;
    logic              r_up_q;
    logic [4*NDIG-1:0] r_digits_out;
    logic              r_err_active;

    state_t            w_state_nxt;
    logic [PH_W-1:0]   w_ph_nxt;
    logic [BL_W-1:0]   w_bl_nxt;
    logic [BL_W-1:0]   w_bl_inc;
    logic              w_err_evt;
    logic              w_ph_last;
    logic [4*NDIG-1:0] w_dig_nxt;
    logic              w_err_nxt;

    assign w_err_evt = start & (up ^ r_up_q);
    assign w_ph_last = (r_ph_cnt == PH_W'(BLINK_DIV - 1));
    assign w_bl_inc  = r_bl_cnt + BL_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph_cnt;
        w_bl_nxt    = r_bl_cnt;
        case (r_state)
            NORM: begin
                if (w_err_evt) begin
                    w_state_nxt = ERR_SHOW;
                    w_ph_nxt    = '0;
                    w_bl_nxt    = '0;
                end
            end
            ERR_SHOW, ERR_BLANK: begin
                if (err_clr) begin
                    w_state_nxt = NORM;
                    w_ph_nxt    = '0;
                end else if (w_err_evt) begin
                    w_state_nxt = ERR_SHOW;
                    w_ph_nxt    = '0;
                    w_bl_nxt    = '0;
                end else if (!w_ph_last) begin
                    w_ph_nxt = r_ph_cnt + PH_W'(1);
                end else if (r_state == ERR_SHOW) begin
                    w_state_nxt = ERR_BLANK;
                    w_ph_nxt    = '0;
                end else begin
                    // With BLINKS == 0 the flash count is unused and held, so it never wraps.
                    w_ph_nxt    = '0;
                    w_state_nxt = ERR_SHOW;
                    if (BLINKS != 0) begin
                        w_bl_nxt = w_bl_inc;
                        if (w_bl_inc == BL_W'(BLINKS)) w_state_nxt = NORM;
                    end
                end
            end
            default: begin
                w_state_nxt = NORM;
                w_ph_nxt    = '0;
                w_bl_nxt    = '0;
            end
        endcase
    end

    // Output mux looks at the next state so the pattern appears at the entry edge.
    always_comb begin
        w_dig_nxt = digits_in;
        w_err_nxt = 1'b0;
        case (w_state_nxt)
            ERR_SHOW: begin
                w_err_nxt = 1'b1;
                for (int i = 0; i < NDIG; i++)
                    w_dig_nxt[4*i +: 4] = (i % 2 == 0) ? ERR_EVEN : ERR_ODD;
            end
            ERR_BLANK: begin
                w_err_nxt = 1'b1;
                for (int i = 0; i < NDIG; i++)
                    w_dig_nxt[4*i +: 4] = blank_sel ? BLANK_CODE : 4'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        r_up_q <= up;
        if (!reset) begin
            r_state      <= NORM;
            r_ph_cnt     <= '0;
            r_bl_cnt     <= '0;
            r_digits_out <= '0;
            r_err_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ph_cnt     <= w_ph_nxt;
            r_bl_cnt     <= w_bl_nxt;
            r_digits_out <= w_dig_nxt;
            r_err_active <= w_err_nxt;
        end
    end

    assign digits_out = r_digits_out;
    assign err_active = r_err_active;

endmodule

// File: doc/stopwatch_disp_err.md
# stopwatch_disp_err

Parametrised display-output stage for the stopwatch: it forwards NDIG BCD digits to the seven-segment decoders. It detects a direction-change-while-running error and replaces the digits with a flashing "F3…F3" pattern. Flash rate and flash count are set by parameters, and the error can be cleared explicitly or ends after a fixed number of flashes. It sits between the counter datapath and the seven-segment decoder bank.

## Interface
- NDIG, 4: number of 4-bit digits; digit 0 is the least significant.
- BLINK_DIV, 25_000_000: clk cycles per flash half-period, ≥2.
- BLINKS, 0: complete show/blank flashes before auto-return to normal; 0 means flash until err_clr.
- ERR_EVEN, 4'h3: code shown on even-index digits during error.
- ERR_ODD, 4'hF: code shown on odd-index digits during error.
- BLANK_CODE, 4'hA: decoder code that turns a digit off.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-low reset.
- up  in  1  count direction (1 = up).
- start  in  1  counter running.
- blank_sel  in  1  blank-phase fill: 1 = BLANK_CODE, 0 = 4'h0.
- err_clr  in  1  single-cycle error acknowledge.
- digits_in  in  4*NDIG  live counter digits.
- digits_out  out  4*NDIG  registered digits to decoders.
- err_active  out  1  registered; 1 while in ERR_SHOW or ERR_BLANK.

## Operation
- **Direction register.**
  - up_q registers up every cycle.
  - On reset, up_q loads the current up, so no false event follows reset.
  - err_evt = start & (up ^ up_q), a combinational pulse.
- **States: NORM, ERR_SHOW, ERR_BLANK.**
  - Phase counter ph_cnt has width $clog2(BLINK_DIV).
  - Flash counter bl_cnt has width $clog2(BLINKS+1), minimum 1.
- **NORM:** on err_evt, go to ERR_SHOW and set ph_cnt = 0 and bl_cnt = 0.
- **ERR_SHOW:**
  - ph_cnt counts up each cycle.
  - At ph_cnt == BLINK_DIV-1, go to ERR_BLANK and set ph_cnt = 0.
- **ERR_BLANK:**
  - ph_cnt counts up each cycle.
  - At ph_cnt == BLINK_DIV-1, set ph_cnt = 0 and increment bl_cnt.
  - If BLINKS != 0 and the incremented bl_cnt == BLINKS, go to NORM; otherwise go to ERR_SHOW.
- **Priority in error states** (highest first):
  1. err_clr goes to NORM.
  2. err_evt retriggers: go to ERR_SHOW, set ph_cnt = 0 and bl_cnt = 0.
  3. Phase/flash progression as above.
- err_clr in NORM is ignored. err_clr and err_evt in the same NORM cycle give an error, because err_clr is not considered in NORM.
- **Output mux,** evaluated on the next state and registered:
  - NORM: digits_in.
  - ERR_SHOW: digit i = ERR_EVEN for even i, ERR_ODD for odd i.
  - ERR_BLANK: every digit = blank_sel ? BLANK_CODE : 4'h0.
- err_active = 1 when the next state is not NORM.
- **Counter wrap:** ph_cnt never exceeds BLINK_DIV-1. bl_cnt does not increment past BLINKS; with BLINKS = 0 it saturates and is unused.

## Timing
- **Reset** (reset = 0 at a rising edge):
  - state = NORM, ph_cnt = 0, bl_cnt = 0.
  - digits_out = 0, err_active = 0.
  - Reset has priority over every other input and aborts flashing immediately.
- **NORM latency:** digits_out equals digits_in sampled at the previous edge (1-cycle latency).
- **Error entry:** with err_evt true in cycle k, digits_out shows the pattern and err_active = 1 from the edge ending cycle k.
- **Phase lengths:** each ERR_SHOW and ERR_BLANK phase lasts exactly BLINK_DIV cycles. A retrigger restarts a full ERR_SHOW phase.
- **Auto-return:** with BLINKS = N, the error lasts exactly 2·N·BLINK_DIV cycles. Then digits_out follows digits_in again with 1-cycle latency, and err_active = 0.
- **err_clr:** when sampled in an error state, digits_out = digits_in and err_active = 0 from that edge.
- **blank_sel:** sampled each cycle, so a mid-phase change affects the next output register.
- **start = 0:** direction changes raise no error.

## Test plan
All scenarios use NDIG=4, BLINK_DIV=4, BLINKS=2, blank_sel=1.
- **Reset and pass-through:** hold reset low for 2 cycles with digits_in=16'h1234 -> digits_out=0 and err_active=0. Release reset -> digits_out=16'h1234 after 1 edge.
- **Idle direction toggle:** start=0, toggle up -> no error; digits_out keeps tracking digits_in.
- **Error with auto-return:** start=1, flip up at cycle k -> from edge k:
  - digits_out=16'hF3F3 for 4 cycles, then 16'hAAAA for 4.
  - This repeats once more (16 cycles total).
  - Then digits_out returns to digits_in and err_active falls.
  - With blank_sel=0, the blank phase shows 16'h0000.
- **Clear mid-flash:** pulse err_clr during ERR_BLANK -> at the next edge digits_out=digits_in and err_active=0. A later err_clr in NORM has no effect.
- **Retrigger:** flip up again during the second ERR_SHOW -> the flash count restarts; 16 more error cycles follow from the retrigger edge.
- **Reset mid-flash and BLINKS=0:**
  - Assert reset during ERR_SHOW -> digits_out=0 next edge, then no error.
  - Rebuild with BLINKS=0, trigger an error -> it flashes for ≥100 cycles until err_clr.
